ifu_prefetch: RTL and testbench
===============================

# ifu_prefetch

Instruction fetch unit with a small prefetch buffer. It owns the PC, fetches 32-bit instructions over a request/grant/response bus, and queues each instruction with its address. It presents them in order to the if_id register, which feeds the decode stage. It redirects on jumps from execute and holds under pipeline stall.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset (bits [1:0] must be 0).
- `DEPTH`, default 2: prefetch buffer entries (≥1).
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `jump_en_i` input 1: redirect request from execute.
- `jump_addr_i` input 32: redirect target; bits [1:0] are forced to 0.
- `hold_i` input 1: downstream stall; the head entry is not consumed.
- `bus_req_o` output 1: fetch request.
- `bus_addr_o` output 32: fetch address; equals the current PC.
- `bus_gnt_i` input 1: request accepted when `bus_req_o && bus_gnt_i` in the same cycle.
- `bus_rvalid_i` input 1: read data valid for the single outstanding request.
- `bus_rdata_i` input 32: instruction word.
- `inst_o` output 32: head instruction; 32'h0000_0013 (NOP) when the buffer is empty.
- `inst_addr_o` output 32: head instruction address; 0 when empty.
- `inst_valid_o` output 1: head valid, consumed when `inst_valid_o && !hold_i`.

## Operation
- **State:** `pc`, `req_addr` (address of the outstanding request), FIFO of `DEPTH` entries holding {addr, inst}, `count`, and FSM `st` ∈ {IDLE, WAIT, DROP}.
- **Reset:** `pc`=RESET_PC, `count`=0, `st`=IDLE. Outputs at reset: `bus_req_o`=0, `inst_valid_o`=0, `inst_o`=NOP, `inst_addr_o`=0.
- **Request:** `bus_req_o` = (st==IDLE) && (count<DEPTH) && !jump_en_i. This is combinational. Retraction before grant is legal.
- **IDLE:**
  - On handshake: `req_addr`←pc, pc←pc+4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0), → WAIT.
  - On `jump_en_i`: pc←{jump_addr_i[31:2],2'b00}, FIFO cleared, stay IDLE.
- **WAIT:**
  - On `bus_rvalid_i` && !jump_en_i: push {req_addr, bus_rdata_i}, → IDLE.
  - On `jump_en_i`: pc←target and FIFO cleared. If `bus_rvalid_i` is also high that cycle, the data is discarded and the FSM goes → IDLE; otherwise → DROP.
- **DROP:**
  - On `bus_rvalid_i`: data discarded, → IDLE.
  - On `jump_en_i`: pc←target, FIFO stays empty, and the FSM stays in DROP unless `bus_rvalid_i` is also high.
- **Outstanding limit:** at most one request outstanding. A push can never overflow, because a request is only issued when count<DEPTH.
- **Pop:** occurs when `inst_valid_o && !hold_i`. A simultaneous push and pop leaves `count` unchanged. A push into an empty FIFO is visible at the output the next cycle; there is no bypass.
- **Output:**
  - `inst_valid_o` = (count!=0) && !jump_en_i.
  - `inst_o`/`inst_addr_o` show the head entry when count!=0, and NOP/0 otherwise.
- **Flush priority:** flush beats push and pop in the same cycle.
- **Reset mid-operation:** any outstanding response arriving after reset release while `st`=IDLE is ignored (`bus_rvalid_i` is only honoured in WAIT/DROP). The bus integrator must not deliver responses for requests issued before reset.

## Timing
- With a zero-wait bus (gnt same cycle, rvalid next cycle), there is one fetch every 2 cycles.
- The first instruction after reset is valid at `inst_o` in cycle 3:
  - cycle 1: request handshake
  - cycle 2: rvalid and push
  - cycle 3: head visible
- Redirect penalty: target request issued the cycle after `jump_en_i` if no response was pending. If one was pending, the target request is issued the cycle after that stale response.
- `hold_i` never blocks fetch until the FIFO is full (count==DEPTH).

## Test plan
- **Reset and sequential fetch:** RESET_PC=0x100, zero-wait bus returning addr^0xA5A5_0000, hold_i=0.
  - Fetch addresses are 0x100, 0x104, 0x108.
  - inst_addr_o follows that sequence with matching data.
  - inst_valid_o first rises in cycle 3.
- **Stall fill:** hold_i=1 from reset, DEPTH=2.
  - Exactly 2 handshakes occur, then `bus_req_o` stays 0.
  - Head remains 0x100 until hold_i drops.
  - Then 0x100 and 0x104 pop on consecutive cycles.
- **Jump while waiting:** issue a request at 0x104, delay rvalid 3 cycles, pulse jump_en_i to 0x2002.
  - Stale data is discarded (DROP).
  - The next request address is 0x2000.
  - No instruction from 0x104 ever appears with inst_valid_o=1.
- **Jump with rvalid in the same cycle:**
  - The response is dropped, FSM → IDLE, and FIFO count=0.
  - The next cycle requests the jump target.
- **Delayed grant / retraction:**
  - gnt held low 4 cycles: `bus_addr_o` stays stable and pc is not advanced.
  - jump during the ungranted request: `bus_req_o` drops that cycle and the next request uses the new target.
- **PC wrap:** RESET_PC=0xFFFF_FFF8.
  - Fetch addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction fetch unit with a small in-order prefetch buffer.
// Owns the PC, issues one fetch at a time over a req/gnt/rvalid bus, queues
// {addr, inst} pairs and presents the oldest one to the if_id register.
// Execute can redirect the PC at any time; a redirect flushes the buffer and
// any response still in flight is discarded.

module ifu_prefetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_i,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   // IDLE: no request outstanding. WAIT: live request outstanding.
   // DROP: request outstanding but its data belongs to a flushed path.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } st_t;

   st_t st, st_nxt;

   logic [31:0]   pc;
   logic [31:0]   req_addr;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   mem_addr [DEPTH];
   logic [31:0]   mem_inst [DEPTH];

   logic [31:0] jump_tgt;
   logic        not_empty;
   logic        handshake;
   logic        push;
   logic        pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   // Bus handshake: bus_req_o may rise and fall freely before it is granted
   // (a redirect retracts it); a request is accepted only in a cycle where
   // bus_req_o && bus_gnt_i. Exactly one response (bus_rvalid_i) follows each
   // accepted request, and no new request is made until it has arrived.
   // The request is also gated by rst_n so nothing is requested while reset
   // is asserted.
   assign jump_tgt     = {jump_addr_i[31:2], 2'b00};
   assign not_empty    = (count != '0);
   assign bus_req_o    = rst_n && (st == IDLE) && (count < DEPTH_C) && !jump_en_i;
   assign bus_addr_o   = pc;
   assign handshake    = bus_req_o && bus_gnt_i;
   assign push         = (st == WAIT) && bus_rvalid_i && !jump_en_i;
   assign inst_valid_o = not_empty && !jump_en_i;
   assign pop          = inst_valid_o && !hold_i;
   assign inst_o       = not_empty ? mem_inst[rd_ptr] : NOP;
   assign inst_addr_o  = not_empty ? mem_addr[rd_ptr] : '0;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   // FSM next state: track whether a response is owed and whether it is stale
   always_comb begin
      st_nxt = st;
      case (st)
         IDLE: begin
            if (handshake) st_nxt = WAIT;
         end
         WAIT: begin
            if (jump_en_i)         st_nxt = bus_rvalid_i ? IDLE : DROP;
            else if (bus_rvalid_i) st_nxt = IDLE;
         end
         DROP: begin
            if (bus_rvalid_i) st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   // PC and outstanding-request address; a redirect overrides any advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else if (jump_en_i) begin
         pc <= jump_tgt;
      end else if (handshake) begin
         req_addr <= pc;
         pc       <= pc + 32'd4;
      end
   end

   // Buffer occupancy and pointers; flush wins over push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (jump_en_i) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Buffer storage; contents are only meaningful below count
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wr_ptr] <= req_addr;
         mem_inst[wr_ptr] <= bus_rdata_i;
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench for ifu_prefetch with a queue-based
// reference model checked every cycle plus hand-computed expectations.

module tb_ifu_prefetch;

   localparam logic [31:0] PC0   = 32'h0000_0100;
   localparam logic [31:0] PCW   = 32'hFFFF_FFF8;
   localparam int          DEPTH = 2;
   localparam logic [31:0] KEY   = 32'hA5A5_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rst2_n;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_i;
   logic        bus_gnt_i;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;

   logic        w_rvalid;
   logic [31:0] w_rdata;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_inst;
   logic [31:0] w_inst_addr;
   logic        w_valid;

   ifu_prefetch #(.RESET_PC(PC0), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .jump_en_i    (jump_en_i),
      .jump_addr_i  (jump_addr_i),
      .hold_i       (hold_i),
      .bus_req_o    (bus_req_o),
      .bus_addr_o   (bus_addr_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o),
      .inst_valid_o (inst_valid_o)
   );

   // Second instance for the PC wrap scenario: zero-wait bus, no hold/jump.
   ifu_prefetch #(.RESET_PC(PCW), .DEPTH(DEPTH)) dut_wrap (
      .clk          (clk),
      .rst_n        (rst2_n),
      .jump_en_i    (1'b0),
      .jump_addr_i  (32'h0),
      .hold_i       (1'b0),
      .bus_req_o    (w_req),
      .bus_addr_o   (w_addr),
      .bus_gnt_i    (1'b1),
      .bus_rvalid_i (w_rvalid),
      .bus_rdata_i  (w_rdata),
      .inst_o       (w_inst),
      .inst_addr_o  (w_inst_addr),
      .inst_valid_o (w_valid)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
   endfunction

   // ---------------- reference model ----------------
   // Fetch behaviour as a queue of {addr, inst} plus a single in-flight slot
   // that may be marked stale by a redirect.
   logic [31:0] m_pc;
   bit          m_out;
   bit          m_stale;
   logic [31:0] m_addr;
   logic [63:0] m_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc    = PC0;
         m_out   = 0;
         m_stale = 0;
         m_addr  = '0;
         m_q.delete();
      end else begin
         bit req;
         bit hs;
         req = !m_out && (m_q.size() < DEPTH) && !jump_en_i;
         hs  = req && bus_gnt_i;
         if (jump_en_i) begin
            m_q.delete();
            m_pc = {jump_addr_i[31:2], 2'b00};
            if (m_out) begin
               if (bus_rvalid_i) begin
                  m_out   = 0;
                  m_stale = 0;
               end else begin
                  m_stale = 1;
               end
            end
         end else begin
            if (m_q.size() != 0 && !hold_i) void'(m_q.pop_front());
            if (m_out && bus_rvalid_i) begin
               if (!m_stale) m_q.push_back({m_addr, bus_rdata_i});
               m_out   = 0;
               m_stale = 0;
            end
            if (hs) begin
               m_out   = 1;
               m_stale = 0;
               m_addr  = m_pc;
               m_pc    = m_pc + 32'd4;
            end
         end
      end
   end

   // ---------------- scoreboard logs ----------------
   logic [31:0] hs_addr_q[$];
   logic [31:0] hs_cyc_q[$];
   logic [31:0] pop_addr_q[$];
   logic [31:0] pop_inst_q[$];
   logic [31:0] pop_cyc_q[$];
   logic [31:0] w_hs_q[$];
   logic [31:0] w_pop_addr_q[$];
   logic [31:0] w_pop_inst_q[$];
   int          first_valid_cyc;
   bit          watch_on;
   logic [31:0] watch_addr;
   int          watch_hits;

   bit          pend_hs;
   logic [31:0] pend_addr;
   bit          w_hs_pend;
   logic [31:0] w_hs_addr;
   int          rv_delay;
   int          rv_cnt;
   logic [31:0] rv_addr;

   // ---------------- compare process (every cycle) ----------------
   always @(negedge clk) begin
      bit          e_req;
      bit          e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_iaddr;
      e_req   = rst_n && !m_out && (m_q.size() < DEPTH) && !jump_en_i;
      e_valid = rst_n && (m_q.size() != 0) && !jump_en_i;
      e_inst  = (m_q.size() != 0) ? m_q[0][31:0]  : NOP;
      e_iaddr = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
      chk("bus_req",    32'(bus_req_o),    32'(e_req));
      chk("bus_addr",   bus_addr_o,        m_pc);
      chk("inst_valid", 32'(inst_valid_o), 32'(e_valid));
      chk("inst",       inst_o,            e_inst);
      chk("inst_addr",  inst_addr_o,       e_iaddr);

      if (rst_n && bus_req_o && bus_gnt_i) begin
         hs_addr_q.push_back(bus_addr_o);
         hs_cyc_q.push_back(32'(cyc));
         pend_hs   = 1;
         pend_addr = bus_addr_o;
      end
      if (rst_n && inst_valid_o && !hold_i) begin
         pop_addr_q.push_back(inst_addr_o);
         pop_inst_q.push_back(inst_o);
         pop_cyc_q.push_back(32'(cyc));
      end
      if (rst_n && inst_valid_o && first_valid_cyc == 0) first_valid_cyc = cyc;
      if (rst_n && inst_valid_o && watch_on && inst_addr_o == watch_addr) watch_hits++;

      if (rst2_n && w_req) begin
         w_hs_q.push_back(w_addr);
         w_hs_pend = 1;
         w_hs_addr = w_addr;
      end
      if (rst2_n && w_valid) begin
         w_pop_addr_q.push_back(w_inst_addr);
         w_pop_inst_q.push_back(w_inst);
      end
   end

   // ---------------- driver tasks ----------------
   // One cycle advance; also plays the bus slave for both instances.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      bus_rvalid_i = 1'b0;
      if (pend_hs) begin
         rv_cnt  = rv_delay;
         rv_addr = pend_addr;
         pend_hs = 0;
      end
      if (rv_cnt > 0) begin
         rv_cnt--;
         if (rv_cnt == 0) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rv_addr ^ KEY;
         end
      end
      w_rvalid  = w_hs_pend;
      w_rdata   = w_hs_addr ^ KEY;
      w_hs_pend = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n           = 1'b0;
      jump_en_i       = 1'b0;
      bus_rvalid_i    = 1'b0;
      pend_hs         = 0;
      rv_cnt          = 0;
      watch_on        = 0;
      watch_hits      = 0;
      first_valid_cyc = 0;
      hs_addr_q.delete();
      hs_cyc_q.delete();
      pop_addr_q.delete();
      pop_inst_q.delete();
      pop_cyc_q.delete();
      @(negedge clk);
      chk("rst_bus_req",    32'(bus_req_o),    32'h0);
      chk("rst_inst_valid", 32'(inst_valid_o), 32'h0);
      chk("rst_inst",       inst_o,            NOP);
      chk("rst_inst_addr",  inst_addr_o,       32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      cyc   = 1;
   endtask

   // Bounded wait for a handshake; returns at the negedge of that cycle.
   task automatic wait_hs(input int budget, output logic [31:0] addr);
      bit ok;
      ok   = 0;
      addr = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus_req_o && bus_gnt_i) begin
            ok   = 1;
            addr = bus_addr_o;
            break;
         end
         tick();
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL hs_timeout: got none expected handshake within %0d cycles", budget);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a;
      rst_n        = 1'b0;
      rst2_n       = 1'b0;
      jump_en_i    = 1'b0;
      jump_addr_i  = '0;
      hold_i       = 1'b0;
      bus_gnt_i    = 1'b1;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      w_rvalid     = 1'b0;
      w_rdata      = '0;
      pend_hs      = 0;
      pend_addr    = '0;
      w_hs_pend    = 0;
      w_hs_addr    = '0;
      rv_delay     = 1;
      rv_cnt       = 0;
      rv_addr      = '0;
      watch_on     = 0;
      watch_addr   = '0;
      watch_hits   = 0;
      first_valid_cyc = 0;

      // Reset and sequential fetch, zero-wait bus
      hold_i    = 1'b0;
      bus_gnt_i = 1'b1;
      rv_delay  = 1;
      do_reset();
      repeat (10) tick();
      chk("seq_hs0",       at(hs_addr_q, 0),  32'h0000_0100);
      chk("seq_hs1",       at(hs_addr_q, 1),  32'h0000_0104);
      chk("seq_hs2",       at(hs_addr_q, 2),  32'h0000_0108);
      chk("seq_first_vld", 32'(first_valid_cyc), 32'd3);
      chk("seq_pop0_addr", at(pop_addr_q, 0), 32'h0000_0100);
      chk("seq_pop0_inst", at(pop_inst_q, 0), 32'hA5A5_0100);
      chk("seq_pop1_addr", at(pop_addr_q, 1), 32'h0000_0104);
      chk("seq_pop1_inst", at(pop_inst_q, 1), 32'hA5A5_0104);
      chk("seq_pop2_addr", at(pop_addr_q, 2), 32'h0000_0108);

      // Stall fill: buffer fills to DEPTH, then fetch stops
      hold_i = 1'b1;
      do_reset();
      repeat (10) tick();
      @(negedge clk);
      chk("fill_hs_count", 32'(hs_addr_q.size()), 32'd2);
      chk("fill_req_low",  32'(bus_req_o),        32'h0);
      chk("fill_head",     inst_addr_o,           32'h0000_0100);
      chk("fill_no_pop",   32'(pop_addr_q.size()), 32'd0);
      tick();
      hold_i = 1'b0;
      repeat (4) tick();
      chk("fill_pop0_addr", at(pop_addr_q, 0), 32'h0000_0100);
      chk("fill_pop1_addr", at(pop_addr_q, 1), 32'h0000_0104);
      chk("fill_pop0_cyc",  at(pop_cyc_q, 0),  32'd12);
      chk("fill_pop1_cyc",  at(pop_cyc_q, 1),  32'd13);

      // Jump while a delayed response is outstanding
      rv_delay = 1;
      do_reset();
      watch_addr = 32'h0000_0104;
      watch_on   = 1;
      wait_hs(10, a);
      chk("jw_hs0", a, 32'h0000_0100);
      tick();
      rv_delay = 3;
      wait_hs(10, a);
      chk("jw_hs1", a, 32'h0000_0104);
      tick();
      tick();
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_2002;
      tick();
      jump_en_i = 1'b0;
      repeat (6) tick();
      chk("jw_tgt_addr", at(hs_addr_q, 2), 32'h0000_2000);
      chk("jw_tgt_cyc",  at(hs_cyc_q, 2),  32'd7);
      chk("jw_no_stale", 32'(watch_hits),  32'd0);
      watch_on = 0;

      // Jump in the same cycle as the response
      rv_delay = 1;
      do_reset();
      watch_addr = 32'h0000_0100;
      watch_on   = 1;
      wait_hs(10, a);
      chk("jr_hs0", a, 32'h0000_0100);
      tick();
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_3000;
      tick();
      jump_en_i = 1'b0;
      @(negedge clk);
      chk("jr_empty", 32'(inst_valid_o), 32'h0);
      chk("jr_req",   32'(bus_req_o),    32'h1);
      chk("jr_addr",  bus_addr_o,        32'h0000_3000);
      repeat (5) tick();
      chk("jr_tgt_cyc",  at(hs_cyc_q, 1),   32'd3);
      chk("jr_no_stale", 32'(watch_hits),   32'd0);
      chk("jr_pop0",     at(pop_addr_q, 0), 32'h0000_3000);
      watch_on = 0;

      // Delayed grant, then retraction by a jump
      bus_gnt_i = 1'b0;
      rv_delay  = 1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("dg_req",  32'(bus_req_o), 32'h1);
         chk("dg_addr", bus_addr_o,     32'h0000_0100);
         tick();
      end
      bus_gnt_i = 1'b1;
      wait_hs(10, a);
      chk("dg_hs0", a, 32'h0000_0100);
      tick();
      bus_gnt_i = 1'b0;
      tick();
      @(negedge clk);
      chk("dg_addr_next", bus_addr_o,     32'h0000_0104);
      chk("dg_req_next",  32'(bus_req_o), 32'h1);
      tick();
      jump_en_i   = 1'b1;
      jump_addr_i = 32'h0000_4001;
      @(negedge clk);
      chk("dg_retract", 32'(bus_req_o), 32'h0);
      tick();
      jump_en_i = 1'b0;
      bus_gnt_i = 1'b1;
      wait_hs(10, a);
      chk("dg_tgt", a, 32'h0000_4000);
      repeat (4) tick();

      // PC wrap on the second instance
      tick();
      rst2_n = 1'b1;
      repeat (10) tick();
      chk("wrap_hs0",       at(w_hs_q, 0),       32'hFFFF_FFF8);
      chk("wrap_hs1",       at(w_hs_q, 1),       32'hFFFF_FFFC);
      chk("wrap_hs2",       at(w_hs_q, 2),       32'h0000_0000);
      chk("wrap_pop0_inst", at(w_pop_inst_q, 0), 32'h5A5A_FFF8);
      chk("wrap_pop2_addr", at(w_pop_addr_q, 2), 32'h0000_0000);
      chk("wrap_pop2_inst", at(w_pop_inst_q, 2), 32'hA5A5_0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
